// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, EX->MEM payload layout and skid-buffer state encodings
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_BEQ = 3'b001;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  localparam int EX_MEM_DW = 32;
  localparam int EX_MEM_RW = 5;

  // Field order here is the packing order used for the flat skid-buffer payload.
  typedef struct packed {
    logic [EX_MEM_DW-1:0] alu_c;
    logic [EX_MEM_RW-1:0] rd;
    logic                 wr_en;
    logic                 mem_rd;
    logic                 mem_wr;
    logic [EX_MEM_DW-1:0] store_data;
  } ex_mem_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } sb_state_e;

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - 2-entry skid buffer with registered in_ready and an external one-cycle input block
module skid_buf2
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  sb_state_e    state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         rdy_q;
  logic         push, pop;
  logic         load_main, load_skid, promote;

  assign push      = in_valid & rdy_q;
  assign out_valid = (state_q != EMPTY);
  assign pop       = out_valid & out_ready;
  assign in_ready  = rdy_q;
  assign out_data  = main_q;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    promote   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (!push && pop) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          load_main = 1'b1;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          promote = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is computed from the next state so it is a clean register output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != TWO) && !block;
      if (load_main)    main_q <= in_data;
      else if (promote) main_q <= skid_q;
      if (load_skid)    skid_q <= in_data;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX->MEM stage: skid-buffered payload, BEQ redirect/flush, debug counters
module ex_mem_stage
  import alu_pkg::*;
#(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_alu_c,
  input  logic [2:0]       in_op,
  input  logic [RW-1:0]    in_rd,
  input  logic             in_wr_en,
  input  logic             in_mem_rd,
  input  logic             in_mem_wr,
  input  logic [DW-1:0]    in_store_data,
  input  logic [DW-1:0]    in_br_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_alu_c,
  output logic [RW-1:0]    out_rd,
  output logic             out_wr_en,
  output logic             out_mem_rd,
  output logic             out_mem_wr,
  output logic [DW-1:0]    out_store_data,
  output logic             br_taken,
  output logic [DW-1:0]    br_pc,
  output logic             flush,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int PW = 2*DW + RW + 3;

  logic          is_beq, accept, taken_now;
  logic          sb_in_valid;
  logic [PW-1:0] sb_in_data, sb_out_data;

  assign is_beq    = (in_op == OP_BEQ);
  assign accept    = in_valid & in_ready;
  assign taken_now = accept & is_beq & in_alu_c[0];

  // BEQ beats are consumed here and never enter the buffer.
  assign sb_in_valid = in_valid & !is_beq;
  assign sb_in_data  = {in_alu_c, in_rd, in_wr_en, in_mem_rd, in_mem_wr, in_store_data};

  skid_buf2 #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (sb_in_valid),
    .in_ready  (in_ready),
    .in_data   (sb_in_data),
    .block     (taken_now),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (sb_out_data)
  );

  assign {out_alu_c, out_rd, out_wr_en, out_mem_rd, out_mem_wr, out_store_data} = sb_out_data;
  assign flush = br_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken    <= 1'b0;
      br_pc       <= '0;
      retired_cnt <= '0;
      taken_cnt   <= '0;
    end else begin
      br_taken <= taken_now;
      if (taken_now) br_pc <= in_br_target;
      if (taken_now && (taken_cnt != '1))
        taken_cnt <= taken_cnt + CNT_W'(1);
      if (out_valid && out_ready && (retired_cnt != '1))
        retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed self-checking bench for ex_mem_stage
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_c;
  logic [2:0]  in_op;
  logic [4:0]  in_rd;
  logic        in_wr_en, in_mem_rd, in_mem_wr;
  logic [31:0] in_store_data, in_br_target;
  logic        out_valid, out_ready;
  logic [31:0] out_alu_c;
  logic [4:0]  out_rd;
  logic        out_wr_en, out_mem_rd, out_mem_wr;
  logic [31:0] out_store_data;
  logic        br_taken, flush;
  logic [31:0] br_pc;
  logic [15:0] retired_cnt, taken_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_c(in_alu_c), .in_op(in_op),
    .in_rd(in_rd), .in_wr_en(in_wr_en), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .in_store_data(in_store_data), .in_br_target(in_br_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_c(out_alu_c), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_store_data(out_store_data), .br_taken(br_taken), .br_pc(br_pc), .flush(flush),
    .retired_cnt(retired_cnt), .taken_cnt(taken_cnt)
  );

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] c, input logic [31:0] tgt);
    in_valid      = v;
    in_op         = op;
    in_alu_c      = c;
    in_br_target  = tgt;
    in_rd         = c[4:0];
    in_wr_en      = c[0];
    in_mem_rd     = c[1];
    in_mem_wr     = c[2];
    in_store_data = c ^ 32'hA5A5_0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [190:0] all_outs();
    return {in_ready, out_valid, out_alu_c, out_rd, out_wr_en, out_mem_rd, out_mem_wr,
            out_store_data, br_taken, br_pc, flush, retired_cnt, taken_cnt, 32'h0};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    total++; if (all_outs() !== '0) $display("FAIL reset_outs all_outs=%h required=0", all_outs()); else passed++;
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_rdy_pre in_ready=%b required=0", in_ready); else passed++;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL reset_rdy_post in_ready=%b required=1", in_ready); else passed++;
    total++; if ({retired_cnt, taken_cnt, out_valid} !== 33'h0) $display("FAIL reset_cnt got=%h required=0", {retired_cnt, taken_cnt, out_valid}); else passed++;
  endtask

  task automatic test_streaming();
    logic [31:0] k32;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      k32 = k;
      if (k >= 1 && k <= 8) begin
        total++;
        if ({out_valid, out_alu_c, out_rd, out_store_data} !== {1'b1, k32, k32[4:0], k32 ^ 32'hA5A5_0000})
          $display("FAIL stream_beat%0d valid=%b c=%0h rd=%0h sd=%h required c=%0h", k, out_valid, out_alu_c, out_rd, out_store_data, k32);
        else passed++;
      end
      if (k <= 8) begin
        total++; if (in_ready !== 1'b1) $display("FAIL stream_rdy%0d in_ready=%b required=1", k, in_ready); else passed++;
      end
      drive(k < 8, 3'b000, k32 + 32'd1, 32'h0);
    end
    total++; if (out_valid !== 1'b0) $display("FAIL stream_drain out_valid=%b required=0", out_valid); else passed++;
    total++; if (retired_cnt !== 16'd8) $display("FAIL stream_retired retired_cnt=%0d required=8", retired_cnt); else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 3'b000, 32'h10, 32'h0);
    @(negedge clk);
    total++; if ({in_ready, out_valid, out_alu_c} !== {2'b11, 32'h10}) $display("FAIL bp_c1 rdy=%b vld=%b c=%0h required 1,1,10", in_ready, out_valid, out_alu_c); else passed++;
    drive(1'b1, 3'b000, 32'h11, 32'h0);
    @(negedge clk);
    total++; if ({in_ready, out_alu_c} !== {1'b0, 32'h10}) $display("FAIL bp_c2 rdy=%b c=%0h required 0,10", in_ready, out_alu_c); else passed++;
    drive(1'b1, 3'b000, 32'h12, 32'h0);
    @(negedge clk);
    total++; if ({in_ready, out_valid, out_alu_c} !== {2'b01, 32'h10}) $display("FAIL bp_hold rdy=%b vld=%b c=%0h required 0,1,10", in_ready, out_valid, out_alu_c); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if ({in_ready, out_alu_c} !== {1'b1, 32'h11}) $display("FAIL bp_b rdy=%b c=%0h required 1,11", in_ready, out_alu_c); else passed++;
    @(negedge clk);
    total++; if ({out_valid, out_alu_c} !== {1'b1, 32'h12}) $display("FAIL bp_c vld=%b c=%0h required 1,12", out_valid, out_alu_c); else passed++;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    total++; if ({out_valid, retired_cnt} !== {1'b0, 16'd3}) $display("FAIL bp_end vld=%b retired=%0d required 0,3", out_valid, retired_cnt); else passed++;
  endtask

  task automatic test_beq_taken();
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 3'b001, 32'h1, 32'h40);
    @(negedge clk);
    total++; if ({br_taken, flush, br_pc} !== {2'b11, 32'h40}) $display("FAIL beq_pulse taken=%b flush=%b pc=%0h required 1,1,40", br_taken, flush, br_pc); else passed++;
    total++; if ({in_ready, out_valid, taken_cnt} !== {2'b00, 16'd1}) $display("FAIL beq_side rdy=%b vld=%b taken_cnt=%0d required 0,0,1", in_ready, out_valid, taken_cnt); else passed++;
    drive(1'b1, 3'b000, 32'h55, 32'h0);
    @(negedge clk);
    total++; if ({br_taken, flush, in_ready, out_valid} !== 4'b0010) $display("FAIL beq_after taken=%b flush=%b rdy=%b vld=%b required 0,0,1,0", br_taken, flush, in_ready, out_valid); else passed++;
    @(negedge clk);
    total++; if ({out_valid, out_alu_c} !== {1'b1, 32'h55}) $display("FAIL beq_next vld=%b c=%0h required 1,55", out_valid, out_alu_c); else passed++;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    total++; if ({retired_cnt, taken_cnt} !== {16'd1, 16'd1}) $display("FAIL beq_cnts retired=%0d taken=%0d required 1,1", retired_cnt, taken_cnt); else passed++;
  endtask

  task automatic test_beq_not_taken();
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 3'b001, 32'h0, 32'h80);
    @(negedge clk);
    drive(1'b1, 3'b001, 32'h2, 32'h84);
    for (int k = 0; k < 2; k++) begin
      total++; if ({br_taken, flush, out_valid, in_ready} !== 4'b0001) $display("FAIL beqnt_c%0d taken=%b flush=%b vld=%b rdy=%b required 0,0,0,1", k, br_taken, flush, out_valid, in_ready); else passed++;
      @(negedge clk);
      drive(1'b0, 3'b000, 32'h0, 32'h0);
    end
    total++; if ({taken_cnt, retired_cnt} !== 32'h0) $display("FAIL beqnt_cnts taken=%0d retired=%0d required 0,0", taken_cnt, retired_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 3'b000, 32'h21, 32'h0);
    @(negedge clk);
    drive(1'b1, 3'b001, 32'h1, 32'h80);
    @(negedge clk);
    total++; if ({br_taken, out_valid} !== 2'b11) $display("FAIL mid_pending taken=%b vld=%b required 1,1", br_taken, out_valid); else passed++;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    total++; if (all_outs() !== '0) $display("FAIL mid_async1 all_outs=%h required=0", all_outs()); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 3'b000, 32'h31, 32'h0);
    @(negedge clk);
    drive(1'b1, 3'b000, 32'h32, 32'h0);
    @(negedge clk);
    total++; if ({in_ready, out_valid} !== 2'b01) $display("FAIL mid_two rdy=%b vld=%b required 0,1", in_ready, out_valid); else passed++;
    drive(1'b1, 3'b001, 32'h1, 32'h90);
    #2 rst_n = 1'b0;
    #1;
    total++; if (all_outs() !== '0) $display("FAIL mid_async2 all_outs=%h required=0", all_outs()); else passed++;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if ({br_taken, out_valid, taken_cnt} !== 18'h0) $display("FAIL mid_after%0d taken=%b vld=%b taken_cnt=%0d required 0,0,0", k, br_taken, out_valid, taken_cnt); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_beq_taken();
    test_beq_not_taken();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
